pingpong_transpose: RTL and testbench
=====================================

# pingpong_transpose

Double-buffered parallel-in, serial-out transpose buffer for the systolic matrix-multiply datapath. It accepts a whole DEPTH-word vector, for example one column of a tile, in a single handshake. It streams the words out one per cycle, lowest index first, under valid/ready flow control. With two banks, the next vector loads while the current one drains, so the array feed never bubbles.

## Interface
- DEPTH, default 8: words per vector; must be ≥2.
- BITS, default 64: bits per word.
- LW, default $clog2(DEPTH+1): width of the length field.
- clk  in  1: clock; all state updates on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- clr  in  1: synchronous flush; empties both banks.
- wr_valid  in  1: producer offers a vector.
- wr_ready  out  1: a bank is free to accept a vector.
- wr_data  in  [BITS-1:0] x [DEPTH-1:0]: vector; element 0 is emitted first.
- wr_len  in  LW: number of words to emit from this vector.
- rd_valid  out  1: rd_data holds a valid word.
- rd_ready  in  1: consumer takes the word.
- rd_data  out  BITS: current word.
- rd_last  out  1: the current word is the final word of its vector.
- occupancy  out  2: number of full banks (0..2).

## Operation
- Each bank holds DEPTH words plus a latched length; each bank is in state EMPTY or FULL.
- Write pointer wsel selects the bank the next write fills. Read pointer rsel selects the bank being drained. Both pointers are 0 after reset and toggle independently.
- Write accept: wr_valid && wr_ready at an edge. The vector is copied into bank wsel, the bank becomes FULL and wsel toggles.
- wr_len is latched at write accept:
  - 0 is treated as DEPTH.
  - Values above DEPTH saturate to DEPTH.
- wr_ready = (occupancy < 2). It is computed from registered state only and never depends on rd_ready or clr in the same cycle.
- rd_valid = (bank rsel is FULL).
- rd_data = bank[rsel].word[idx], where idx is the read index.
- rd_last = rd_valid && (idx == len-1).
- Read accept: rd_valid && rd_ready at an edge.
  - If the word is not the last, idx increments.
  - If the word is the last, idx returns to 0, bank rsel becomes EMPTY and rsel toggles.
- Simultaneous write accept and last-word read accept in the same cycle: both take effect, and occupancy is unchanged.
- With rd_ready held high, consecutive vectors drain back-to-back with no idle cycle between them.
- clr has priority over everything else:
  - Both banks become EMPTY; idx, wsel and rsel return to 0.
  - A write or read offered in that cycle is dropped.
  - Stored data need not be cleared.
- Reset values:
  - wr_ready = 1; rd_valid = 0; rd_last = 0; occupancy = 0.
  - rd_data = 0; all storage is reset to 0.
- Reset asserted mid-drain abandons the vector; the buffer is empty after release.

## Timing
- Write-to-read latency is 1 cycle: a vector accepted at edge N gives rd_valid=1 and word 0 on rd_data after edge N, if the buffer was empty.
- rd_data, rd_last and rd_valid are combinational from registered state, with no input-to-output path.
- Holding rules:
  - While rd_valid && !rd_ready, rd_data and rd_last hold stable.
  - A pending write does not disturb the bank being read.
- Throughput is 1 word per cycle on the read side, and 1 vector per cycle on the write side while a bank is free.

## Configuration
- DOUBLE_BUF_EN defined: two banks as above; occupancy ranges 0..2.
- DOUBLE_BUF_EN undefined: a single bank.
  - wr_ready = (occupancy == 0); wsel and rsel are fixed at 0.
  - A write in the cycle of the last-word read is not accepted; the next vector's word 0 appears two cycles after the last word is taken (one cycle for ready to rise, one for write-to-read latency).
  - occupancy ranges 0..1; all other behaviour is identical.

## Structure
- Package transpose_pkg:
  - bank_state_e enum {EMPTY, FULL}.
  - A len_t typedef sized from DEPTH.
  - A function sat_len() implementing the 0→DEPTH and saturation rules.
- Sub-module transpose_bank, instantiated once or twice, contains:
  - DEPTH×BITS storage with async reset to 0, plus the latched len and the state flop.
  - Load strobe and release strobe inputs.
  - A word-select read port.
- The top level holds wsel, rsel, idx, the handshake logic and the occupancy count.

## Test plan
- Reset then a single vector: write {0x10,0x11,…,0x17} with wr_len=8 and rd_ready=1 → rd_data 0x10..0x17 on 8 consecutive cycles, rd_last only on 0x17, then rd_valid=0.
- Length rules:
  - wr_len=3 → only 3 words, rd_last on the third.
  - wr_len=0 → 8 words.
  - wr_len=15 with LW=4 → saturates to 8 words.
- Back-to-back: vectors A and B on consecutive cycles with rd_ready=1 → A0..A7 then B0..B7 with no gap, occupancy sequence 1,2,1,…. With DOUBLE_BUF_EN undefined → the next vector's word 0 appears two cycles after the last word is taken.
- Backpressure: rd_ready=0 for 5 cycles mid-vector → rd_data holds; with both banks full, wr_ready=0 and a third write is refused.
- Simultaneous events: third write offered in the same cycle as the last-word read with both banks full → refused (wr_ready=0), accepted the next cycle.
- Flush and reset:
  - clr asserted mid-drain with a write in the same cycle → both dropped; occupancy=0 and rd_valid=0 next cycle.
  - rst_n pulsed low asynchronously mid-drain → all outputs at reset values immediately.

Source files
------------

// File: rtl/transpose_pkg.sv
// Shared types and helpers for the ping-pong transpose buffer.
// Optional feature macro: DOUBLE_BUF_EN (two banks when defined, one bank otherwise).
package transpose_pkg;

  // Default geometry of one vector: words per vector and bits per word.
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_BITS  = 64;
  localparam int DEFAULT_LW    = $clog2(DEFAULT_DEPTH + 1);

  // Each bank is either waiting for a vector or holding one that is not yet drained.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  // Length field wide enough to hold the value DEPTH itself.
  typedef logic [DEFAULT_LW-1:0] len_t;

  // A requested length of zero means a whole vector, and anything longer than a
  // vector is clipped to the vector size.
  function automatic int unsigned sat_len(input int unsigned len, input int unsigned depth);
    if ((len == 0) || (len > depth)) begin
      return depth;
    end
    return len;
  endfunction

endpackage

// File: rtl/pingpong_transpose_if.sv
// Producer/consumer bus of the ping-pong transpose buffer.
// The slave modport is the buffer's view; the master modport drives the buffer.
// Optional feature macro: DOUBLE_BUF_EN (affects only the buffer, not this bus).
interface pingpong_transpose_if
  import transpose_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BITS  = DEFAULT_BITS,
  parameter int LW    = $clog2(DEPTH + 1)
);

  // Write side: a whole vector per handshake.
  logic                        wr_valid;
  logic                        wr_ready;
  logic [DEPTH-1:0][BITS-1:0]  wr_data;
  logic [LW-1:0]               wr_len;

  // Read side: one word per handshake.
  logic                        rd_valid;
  logic                        rd_ready;
  logic [BITS-1:0]             rd_data;
  logic                        rd_last;

  // Number of banks currently holding a vector.
  logic [1:0]                  occupancy;

  modport slave (
    input  wr_valid, wr_data, wr_len, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last, occupancy
  );

  modport master (
    output wr_valid, wr_data, wr_len, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last, occupancy
  );

endinterface

// File: rtl/transpose_bank.sv
// One storage bank of the transpose buffer: a full vector, its latched length
// and an EMPTY/FULL state flag, with a word-select read port.
// Optional feature macro: DOUBLE_BUF_EN (decides how many banks the top builds).
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BITS  = DEFAULT_BITS,
  parameter int LW    = $clog2(DEPTH + 1),
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic                       i_release,
  input  logic [DEPTH-1:0][BITS-1:0] i_data,
  input  logic [LW-1:0]              i_len,
  input  logic [IW-1:0]              i_sel,
  output logic                       o_full,
  output logic [LW-1:0]              o_len,
  output logic [BITS-1:0]            o_word
);

  logic [DEPTH-1:0][BITS-1:0] r_mem;
  logic [LW-1:0]              r_len;
  bank_state_e                r_state;

  // Capture the whole vector and its already-saturated length when loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_len <= '0;
    end else if (i_load) begin
      r_mem <= i_data;
      r_len <= i_len;
    end
  end

  // Release wins so a flush always empties the bank, even if a load races it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else if (i_release) begin
      r_state <= EMPTY;
    end else if (i_load) begin
      r_state <= FULL;
    end
  end

  assign o_full = (r_state == FULL);
  assign o_len  = r_len;
  assign o_word = r_mem[i_sel];

endmodule

// File: rtl/pingpong_transpose.sv
// Parallel-in, serial-out transpose buffer feeding the systolic array.
// A whole vector is written in one handshake and drained one word per cycle,
// lowest index first. With DOUBLE_BUF_EN defined two banks alternate so the
// next vector loads while the current one drains; without it a single bank is
// used and a new vector is only accepted once the previous one is fully read.
module pingpong_transpose
  import transpose_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BITS  = DEFAULT_BITS,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  pingpong_transpose_if.slave  bus
);

`ifdef DOUBLE_BUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int IW = $clog2(DEPTH);

  // Per-bank views; bank 1 reads as permanently empty in single-bank builds so
  // the pointer muxes below look the same in both configurations.
  logic [1:0]           w_bankFull;
  logic [1:0][LW-1:0]   w_bankLen;
  logic [1:0][BITS-1:0] w_bankWord;

  logic          r_wsel;
  logic          r_rsel;
  logic [IW-1:0] r_idx;
  logic [1:0]    r_occupancy;

  logic          w_wrReady;
  logic          w_rdValid;
  logic          w_rdLast;
  logic [LW-1:0] w_curLen;
  logic [LW-1:0] w_satLen;
  logic          w_wrAccept;
  logic          w_rdAccept;
  logic          w_rdDone;

  // Write readiness looks only at the registered bank count, never at the
  // consumer or the flush in the same cycle, so no combinational loop can form.
  assign w_wrReady = (r_occupancy < 2'(NBANK));

  assign w_rdValid = w_bankFull[r_rsel];
  assign w_curLen  = w_bankLen[r_rsel];
  assign w_rdLast  = w_rdValid && (LW'(r_idx) == (w_curLen - LW'(1)));

  assign w_satLen  = LW'(sat_len(32'(bus.wr_len), 32'(DEPTH)));

  // A flush swallows any handshake offered in the same cycle.
  assign w_wrAccept = !clr && bus.wr_valid && w_wrReady;
  assign w_rdAccept = !clr && w_rdValid && bus.rd_ready;
  assign w_rdDone   = w_rdAccept && w_rdLast;

  assign bus.wr_ready  = w_wrReady;
  assign bus.rd_valid  = w_rdValid;
  assign bus.rd_data   = w_bankWord[r_rsel];
  assign bus.rd_last   = w_rdLast;
  assign bus.occupancy = r_occupancy;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NBANK) begin : g_inst
      logic w_load;
      logic w_release;

      assign w_load    = w_wrAccept && (r_wsel == 1'(b));
      assign w_release = clr || (w_rdDone && (r_rsel == 1'(b)));

      transpose_bank #(
        .DEPTH (DEPTH),
        .BITS  (BITS),
        .LW    (LW),
        .IW    (IW)
      ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_release (w_release),
        .i_data    (bus.wr_data),
        .i_len     (w_satLen),
        .i_sel     (r_idx),
        .o_full    (w_bankFull[b]),
        .o_len     (w_bankLen[b]),
        .o_word    (w_bankWord[b])
      );
    end else begin : g_none
      assign w_bankFull[b] = 1'b0;
      assign w_bankLen[b]  = '0;
      assign w_bankWord[b] = '0;
    end
  end

  // Write pointer: advance to the other bank after each accepted vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wsel <= 1'b0;
    end else if (clr) begin
      r_wsel <= 1'b0;
    end else if (w_wrAccept && (NBANK == 2)) begin
      r_wsel <= ~r_wsel;
    end
  end

  // Read pointer and word index: step through the vector, then hand over to
  // the other bank so back-to-back vectors drain without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsel <= 1'b0;
      r_idx  <= '0;
    end else if (clr) begin
      r_rsel <= 1'b0;
      r_idx  <= '0;
    end else if (w_rdAccept) begin
      if (w_rdLast) begin
        r_idx <= '0;
        if (NBANK == 2) begin
          r_rsel <= ~r_rsel;
        end
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // Bank count: a load and a final-word read in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occupancy <= 2'd0;
    end else if (clr) begin
      r_occupancy <= 2'd0;
    end else begin
      case ({w_wrAccept, w_rdDone})
        2'b10:   r_occupancy <= r_occupancy + 2'd1;
        2'b01:   r_occupancy <= r_occupancy - 2'd1;
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_transpose.sv
// Scoreboard bench for pingpong_transpose. The reference model is a queue of
// expected output words (each tagged with whether it ends its vector); the
// number of stored vectors is the number of tagged words still queued.
// Optional feature macro: DOUBLE_BUF_EN (bench follows the same setting).
module tb_pingpong_transpose;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef logic [DEPTH-1:0][BITS-1:0] vec_t;
  typedef struct packed {
    logic [BITS-1:0] data;
    logic            last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  pingpong_transpose_if #(.DEPTH(DEPTH), .BITS(BITS), .LW(LW)) bus ();

  pingpong_transpose #(.DEPTH(DEPTH), .BITS(BITS), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [BITS-1:0] actual,
                             input logic [BITS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int expBanks();
    int n = 0;
    foreach (expQ[i]) if (expQ[i].last) n++;
    return n;
  endfunction

  task automatic pushVector(input vec_t v, input logic [LW-1:0] len);
    int n;
    n = ((len == 0) || (int'(len) > DEPTH)) ? DEPTH : int'(len);
    for (int i = 0; i < n; i++) expQ.push_back('{data: v[i], last: (i == n - 1)});
  endtask

  function automatic vec_t seqVec(input int base);
    vec_t v;
    for (int i = 0; i < DEPTH; i++) v[i] = BITS'(base + i);
    return v;
  endfunction

  function automatic vec_t randVec();
    vec_t v;
    for (int i = 0; i < DEPTH; i++) v[i] = {$urandom, $urandom};
    return v;
  endfunction

  // Monitor: compares DUT outputs with the model every cycle, then advances the
  // model by the handshakes the model says happen at the next rising edge.
  initial begin : monitor
    int              banks;
    logic            expValid, expReady, pendClr, pendWr, pendRd;
    vec_t            pendData;
    logic [LW-1:0]   pendLen;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        expQ.delete();
        checkOutput("reset wr_ready",  BITS'(bus.wr_ready),  BITS'(1));
        checkOutput("reset rd_valid",  BITS'(bus.rd_valid),  BITS'(0));
        checkOutput("reset rd_last",   BITS'(bus.rd_last),   BITS'(0));
        checkOutput("reset occupancy", BITS'(bus.occupancy), BITS'(0));
        checkOutput("reset rd_data",   bus.rd_data,          BITS'(0));
      end else begin
        banks    = expBanks();
        expValid = (expQ.size() > 0);
        expReady = (banks < NB);
        checkOutput("rd_valid",  BITS'(bus.rd_valid),  BITS'(expValid));
        checkOutput("wr_ready",  BITS'(bus.wr_ready),  BITS'(expReady));
        checkOutput("occupancy", BITS'(bus.occupancy), BITS'(banks));
        if (expValid) begin
          checkOutput("rd_data", bus.rd_data,        expQ[0].data);
          checkOutput("rd_last", BITS'(bus.rd_last), BITS'(expQ[0].last));
        end else begin
          checkOutput("idle rd_last", BITS'(bus.rd_last), BITS'(0));
        end
        pendClr  = clr;
        pendWr   = bus.wr_valid && expReady;
        pendRd   = expValid && bus.rd_ready;
        pendData = bus.wr_data;
        pendLen  = bus.wr_len;
        @(posedge clk);
        if (rst_n) begin
          if (pendClr) begin
            expQ.delete();
          end else begin
            if (pendRd) void'(expQ.pop_front());
            if (pendWr) pushVector(pendData, pendLen);
          end
        end
      end
    end
  end

  // Offer one vector and hold it until taken; called and returns at posedge+1.
  task automatic applyStimulus(input vec_t v, input logic [LW-1:0] len);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = v;
    bus.wr_len   = len;
    forever begin
      @(negedge clk);
      if (bus.wr_ready) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("[TB] FAIL write timeout: wr_ready stayed 0, expected 1 within 500 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
  endtask

  // Wait until the buffer reports nothing left to read.
  task automatic waitDrain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!bus.rd_valid) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain timeout: rd_valid stayed 1, expected 0 within 2000 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic accepted;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_len   = '0;
    bus.rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single full vector of sequential words.
    bus.rd_ready = 1'b1;
    applyStimulus(seqVec(32'h10), LW'(8));
    waitDrain();

    // Length rules: short, zero and oversized lengths.
    applyStimulus(randVec(), LW'(3));
    waitDrain();
    applyStimulus(randVec(), LW'(0));
    waitDrain();
    applyStimulus(randVec(), LW'(15));
    waitDrain();

    // Back-to-back vectors.
    applyStimulus(randVec(), LW'(8));
    applyStimulus(randVec(), LW'(8));
    waitDrain();

    // Consumer stall mid-vector while more vectors queue up behind it.
    applyStimulus(randVec(), LW'(8));
    repeat (3) @(posedge clk);
    #1 bus.rd_ready = 1'b0;
    fork
      begin
        applyStimulus(randVec(), LW'(8));
        applyStimulus(randVec(), LW'(5));
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.rd_ready = 1'b1;
      end
    join
    waitDrain();

    // Flush mid-drain with a write offered in the same cycle.
    applyStimulus(randVec(), LW'(8));
    repeat (2) @(posedge clk);
    #1;
    clr          = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = randVec();
    bus.wr_len   = LW'(8);
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-drain, then normal operation again.
    applyStimulus(randVec(), LW'(8));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(seqVec(32'h40), LW'(4));
    waitDrain();

    // Randomised traffic with backpressure and occasional flushes.
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      accepted = bus.wr_valid && bus.wr_ready && !clr;
      @(posedge clk);
      #1;
      clr = ($urandom_range(0, 99) == 0);
      if (!bus.wr_valid || accepted) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.wr_valid = 1'b1;
          bus.wr_data  = randVec();
          bus.wr_len   = LW'($urandom_range(0, 15));
        end else begin
          bus.wr_valid = 1'b0;
        end
      end
      bus.rd_ready = ($urandom_range(0, 3) != 0);
    end
    clr          = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    waitDrain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
